sdpram_bist_engine: RTL and testbench

//  Synthesisable write/read/compare engine for a simple dual-port RAM (DDS wave RAM class).

---
 rtl/sdpram_bist_engine.sv | 202 ++++++++++++++++++++
 tb/tb_sdpram_bist_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_bist_engine.sv
// Write/read/compare BIST engine for a simple dual-port wave RAM, single clock domain.
// Optional BIST_READ_ONLY_EN: mode 11 skips the fill and checks a preloaded down-count table.
module sdpram_bist_engine #(
    parameter int ADDR_WIDTH    = 14,
    parameter int DATA_WIDTH    = 8,
    parameter int RD_LATENCY    = 2,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     wr_clk,
    input  logic                     tb_wr_rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     ram_wr_en,
    output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
    output logic                     ram_rd_en,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int                  LAST       = RD_LATENCY - 1;
    localparam logic [2:0]          DRAIN_LAST = 3'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH-1:0] even_bits();
        logic [DATA_WIDTH-1:0] v;
        for (int i = 0; i < DATA_WIDTH; i++) v[i] = ((i % 2) == 0);
        return v;
    endfunction

    localparam logic [DATA_WIDTH-1:0] PAT_EVEN = even_bits();

    // Mode 11 always expects the down-count table, with or without the read-only build.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0]            m,
                                                      input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] a_dw;
        logic [DATA_WIDTH-1:0] res;
        a_dw = DATA_WIDTH'(a);
        case (m)
            2'b01:   res = a_dw;
            2'b10:   res = a[0] ? ~PAT_EVEN : PAT_EVEN;
            default: res = {DATA_WIDTH{1'b1}} - a_dw;
        endcase
        return res;
    endfunction

    state_t                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [ADDR_WIDTH:0]      wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH:0]      rd_cnt_q, rd_cnt_d;
    logic [2:0]               drain_cnt_q, drain_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]    first_err_q, first_err_d;
    logic                     pass_q, pass_d;
    logic                     pipe_vld_q  [RD_LATENCY];
    logic                     pipe_vld_d  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]    pipe_addr_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]    pipe_addr_d [RD_LATENCY];
    logic [DATA_WIDTH-1:0]    pipe_exp_q  [RD_LATENCY];
    logic [DATA_WIDTH-1:0]    pipe_exp_d  [RD_LATENCY];
    logic                     mismatch;

    // A finished sweep leaves the counter at 2**AW; its last issued address was all-ones.
    always_comb begin
        ram_wr_addr = wr_cnt_q[ADDR_WIDTH] ? '1 : wr_cnt_q[ADDR_WIDTH-1:0];
        ram_rd_addr = rd_cnt_q[ADDR_WIDTH] ? '1 : rd_cnt_q[ADDR_WIDTH-1:0];
        ram_wr_data = ram_wr_en ? pattern(mode_q, ram_wr_addr) : '0;
        mismatch    = pipe_vld_q[LAST] && (ram_rd_data != pipe_exp_q[LAST]);
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        ram_wr_en   = 1'b0;
        ram_rd_en   = 1'b0;
        done        = 1'b0;

        if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) first_err_d = pipe_addr_q[LAST];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    wr_cnt_d    = '0;
                    rd_cnt_d    = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                    state_d     = S_WRITE;
`ifdef BIST_READ_ONLY_EN
                    if (mode == 2'b11) state_d = S_READ;
`endif
                end
            end
            S_WRITE: begin
                ram_wr_en = 1'b1;
                wr_cnt_d  = wr_cnt_q + CNT_ONE;
                if (wr_cnt_d[ADDR_WIDTH]) state_d = S_GAP;
            end
            S_GAP: begin
                rd_cnt_d = '0;
                state_d  = S_READ;
            end
            S_READ: begin
                ram_rd_en = 1'b1;
                rd_cnt_d  = rd_cnt_q + CNT_ONE;
                if (rd_cnt_d[ADDR_WIDTH]) begin
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 3'd1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    // Includes the compare happening in this final drain cycle.
                    pass_d  = (err_cnt_d == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy = (state_q != S_IDLE) && (state_q != S_DONE);

        pipe_vld_d  = pipe_vld_q;
        pipe_addr_d = pipe_addr_q;
        pipe_exp_d  = pipe_exp_q;
        for (int i = RD_LATENCY - 1; i > 0; i--) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
            pipe_exp_d[i]  = pipe_exp_q[i-1];
        end
        pipe_vld_d[0]  = ram_rd_en;
        pipe_addr_d[0] = ram_rd_addr;
        pipe_exp_d[0]  = pattern(mode_q, ram_rd_addr);
    end

    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            drain_cnt_q <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            // NOTE: the compare pipeline is reset (unlike a RAM) so no stale valid survives an abort.
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_addr_q[i] <= '0;
                pipe_exp_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_addr_q <= pipe_addr_d;
            pipe_exp_q  <= pipe_exp_d;
        end
    end

endmodule

// File: tb/tb_sdpram_bist_engine.sv
// Self-checking bench: two engines (read latency 2 and 1) on 16-word RAM models with fault injection.
// Table-driven runs, write/read scoreboards, plus hand-written reset-abort sequence.
module tb_sdpram_bist_engine;

    typedef enum logic [1:0] {F_NONE, F_FLIP, F_STUCK0} fault_e;

    typedef struct {
        bit         sel;        // 0: latency-2 engine, 1: latency-1 engine
        logic [1:0] mode;
        fault_e     fault;
        logic [3:0] fault_addr;
        bit         preload;
        bit         poke;       // extra start pulse while busy
        bit         exp_writes;
        int         exp_cycle;
        bit         exp_pass;
        logic [2:0] exp_err;
        logic [3:0] exp_first;
    } vec_t;

`ifdef BIST_READ_ONLY_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [1:0] mode = 2'b00;

    logic       a_wr_en, a_rd_en, a_busy, a_done, a_pass;
    logic [3:0] a_wr_addr, a_rd_addr, a_first;
    logic [7:0] a_wr_data, a_rd_data;
    logic [2:0] a_err;
    logic       b_wr_en, b_rd_en, b_busy, b_done, b_pass;
    logic [3:0] b_wr_addr, b_rd_addr, b_first;
    logic [7:0] b_wr_data, b_rd_data;
    logic [2:0] b_err;

    int n_cmp = 0;
    int n_bad = 0;

    fault_e     fault_sel  = F_NONE;
    logic [3:0] fault_addr = 4'd0;
    logic       load_req   = 1'b0;
    logic       load_pre   = 1'b0;
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] a_r1, a_r2, b_r1;

    logic [11:0] wq_a[$], wq_b[$];
    logic [3:0]  rq_a[$], rq_b[$];

    always #5 clk = ~clk;

    sdpram_bist_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) dut (
        .wr_clk(clk), .tb_wr_rst(rst), .start(start_a), .mode(mode),
        .ram_wr_en(a_wr_en), .ram_wr_addr(a_wr_addr), .ram_wr_data(a_wr_data),
        .ram_rd_addr(a_rd_addr), .ram_rd_en(a_rd_en), .ram_rd_data(a_rd_data),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err), .first_err_addr(a_first));

    sdpram_bist_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) dut_l1 (
        .wr_clk(clk), .tb_wr_rst(rst), .start(start_b), .mode(mode),
        .ram_wr_en(b_wr_en), .ram_wr_addr(b_wr_addr), .ram_wr_data(b_wr_data),
        .ram_rd_addr(b_rd_addr), .ram_rd_en(b_rd_en), .ram_rd_data(b_rd_data),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err), .first_err_addr(b_first));

    function automatic logic [7:0] corrupt(input logic [3:0] addr, input logic [7:0] d);
        case (fault_sel)
            F_FLIP:   return (addr == fault_addr) ? (d ^ 8'h01) : d;
            F_STUCK0: return d & 8'hFE;
            default:  return d;
        endcase
    endfunction

    function automatic logic [7:0] exp_pat(input logic [1:0] m, input logic [3:0] a);
        case (m)
            2'b01:   return {4'h0, a};
            2'b10:   return a[0] ? 8'hAA : 8'h55;
            default: return 8'hFF - {4'h0, a};
        endcase
    endfunction

    // RAM models: continuous reads, 2-stage and 1-stage read paths
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= load_pre ? (8'hFF - 8'(i)) : (8'h3C ^ 8'(i));
        end else if (a_wr_en) begin
            mem_a[a_wr_addr] <= a_wr_data;
        end
        a_r1 <= corrupt(a_rd_addr, mem_a[a_rd_addr]);
        a_r2 <= a_r1;
    end
    assign a_rd_data = a_r2;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= load_pre ? (8'hFF - 8'(i)) : (8'h3C ^ 8'(i));
        end else if (b_wr_en) begin
            mem_b[b_wr_addr] <= b_wr_data;
        end
        b_r1 <= corrupt(b_rd_addr, mem_b[b_rd_addr]);
    end
    assign b_rd_data = b_r1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: every write/read strobe must match the next expected entry
    always @(negedge clk) begin
        if (a_wr_en) begin
            if (wq_a.size() == 0) check("wr_unexpected_a", {a_wr_addr, a_wr_data}, 32'hFFFF_FFFF);
            else check("wr_a", {a_wr_addr, a_wr_data}, wq_a.pop_front());
        end
        if (a_rd_en) begin
            if (rq_a.size() == 0) check("rd_unexpected_a", a_rd_addr, 32'hFFFF_FFFF);
            else check("rd_a", a_rd_addr, rq_a.pop_front());
        end
        if (b_wr_en) begin
            if (wq_b.size() == 0) check("wr_unexpected_b", {b_wr_addr, b_wr_data}, 32'hFFFF_FFFF);
            else check("wr_b", {b_wr_addr, b_wr_data}, wq_b.pop_front());
        end
        if (b_rd_en) begin
            if (rq_b.size() == 0) check("rd_unexpected_b", b_rd_addr, 32'hFFFF_FFFF);
            else check("rd_b", b_rd_addr, rq_b.pop_front());
        end
    end

    function automatic vec_t mk(input bit sel, input logic [1:0] m, input fault_e f,
                                input logic [3:0] fa, input bit pre, input bit poke,
                                input bit wr, input int cyc, input bit p,
                                input logic [2:0] e, input logic [3:0] fe);
        vec_t v;
        v.sel = sel; v.mode = m; v.fault = f; v.fault_addr = fa; v.preload = pre;
        v.poke = poke; v.exp_writes = wr; v.exp_cycle = cyc; v.exp_pass = p;
        v.exp_err = e; v.exp_first = fe;
        return v;
    endfunction

    task automatic prepare(input vec_t v);
        fault_sel  = v.fault;
        fault_addr = v.fault_addr;
        load_pre   = v.preload;
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
        wq_a.delete(); wq_b.delete(); rq_a.delete(); rq_b.delete();
        for (int a = 0; a < 16; a++) begin
            if (v.exp_writes) begin
                if (v.sel) wq_b.push_back({4'(a), exp_pat(v.mode, 4'(a))});
                else       wq_a.push_back({4'(a), exp_pat(v.mode, 4'(a))});
            end
            if (v.sel) rq_b.push_back(4'(a));
            else       rq_a.push_back(4'(a));
        end
        mode = v.mode;
        if (v.sel) start_b = 1'b1;
        else       start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        prepare(v);
        cyc = 1;
        check($sformatf("v%0d_busy_c1", idx), v.sel ? b_busy : a_busy, 1);
        while (!(v.sel ? b_done : a_done) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            // start and a different mode while busy must both be ignored
            start_a = v.poke && !v.sel && (cyc == 5);
            start_b = v.poke && v.sel && (cyc == 5);
            mode    = (v.poke && cyc == 5) ? ~v.mode : v.mode;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check($sformatf("v%0d_done_cycle", idx), cyc, v.exp_cycle);
        check($sformatf("v%0d_result", idx),
              v.sel ? {b_busy, b_pass, b_err, b_first} : {a_busy, a_pass, a_err, a_first},
              {1'b0, v.exp_pass, v.exp_err, v.exp_first});
        @(negedge clk);
        @(negedge clk);
        check($sformatf("v%0d_held", idx),
              v.sel ? {b_done, b_busy, b_pass, b_err, b_first} : {a_done, a_busy, a_pass, a_err, a_first},
              {1'b0, 1'b0, v.exp_pass, v.exp_err, v.exp_first});
        check($sformatf("v%0d_sb_left", idx),
              v.sel ? (wq_b.size() + rq_b.size()) : (wq_a.size() + rq_a.size()), 0);
    endtask

    vec_t vecs[10];

    initial begin
        int full_a, full_b, ro_a;
        int cyc, dones;
        vec_t rv;
        full_a = 36; full_b = 35; ro_a = RO ? 19 : 36;
        vecs[0] = mk(1'b0, 2'b00, F_NONE,   4'd0,  1'b0, 1'b0, 1'b1, full_a, 1'b1, 3'd0, 4'd0);
        vecs[1] = mk(1'b0, 2'b00, F_FLIP,   4'd5,  1'b0, 1'b0, 1'b1, full_a, 1'b0, 3'd1, 4'd5);
        vecs[2] = mk(1'b0, 2'b00, F_STUCK0, 4'd0,  1'b0, 1'b0, 1'b1, full_a, 1'b0, 3'd7, 4'd0);
        vecs[3] = mk(1'b1, 2'b10, F_NONE,   4'd0,  1'b0, 1'b0, 1'b1, full_b, 1'b1, 3'd0, 4'd0);
        vecs[4] = mk(1'b1, 2'b10, F_FLIP,   4'd5,  1'b0, 1'b0, 1'b1, full_b, 1'b0, 3'd1, 4'd5);
        vecs[5] = mk(1'b0, 2'b01, F_FLIP,   4'd9,  1'b0, 1'b0, 1'b1, full_a, 1'b0, 3'd1, 4'd9);
        vecs[6] = mk(1'b1, 2'b01, F_NONE,   4'd0,  1'b0, 1'b1, 1'b1, full_b, 1'b1, 3'd0, 4'd0);
        vecs[7] = mk(1'b0, 2'b00, F_FLIP,   4'd15, 1'b0, 1'b1, 1'b1, full_a, 1'b0, 3'd1, 4'd15);
        vecs[8] = mk(1'b0, 2'b11, F_NONE,   4'd0,  1'b1, 1'b0, !RO,  ro_a,   1'b1, 3'd0, 4'd0);
        vecs[9] = mk(1'b0, 2'b11, F_STUCK0, 4'd0,  1'b1, 1'b0, !RO,  ro_a,   1'b0, 3'd7, 4'd0);

        // Reset state of both engines
        @(negedge clk);
        check("reset_a", {a_wr_en, a_wr_addr, a_wr_data, a_rd_addr, a_rd_en, a_busy, a_done, a_pass, a_err, a_first}, 0);
        check("reset_b", {b_wr_en, b_wr_addr, b_wr_data, b_rd_addr, b_rd_en, b_busy, b_done, b_pass, b_err, b_first}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset mid-READ aborts the run: outputs clear, no done pulse follows
        rv = mk(1'b0, 2'b00, F_FLIP, 4'd2, 1'b0, 1'b0, 1'b1, 36, 1'b0, 3'd1, 4'd2);
        prepare(rv);
        cyc = 1;
        while (cyc < 25) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_pre_err", {a_busy, a_rd_en, a_err, a_first}, {1'b1, 1'b1, 3'd1, 4'd2});
        rst = 1'b1;
        #1;
        check("abort_in_reset", {a_wr_en, a_wr_addr, a_wr_data, a_rd_addr, a_rd_en, a_busy, a_done, a_pass, a_err, a_first}, 0);
        wq_a.delete(); rq_a.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_done || a_busy) dones++;
        end
        check("abort_no_done", dones, 0);
        run_vec(vecs[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
